// File: rtl/ex_dm_pipe_if.sv
// EX->DM stage bus: upstream beat handshake, downstream beat handshake, flush.
// slave = the pipeline stage, master = whatever drives EX side and consumes DM side.
interface ex_dm_pipe_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              flush;
  // EX side
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] write_data_in;
  logic [RD_W-1:0]   rd_in;
  logic              mem_read_in;
  logic              mem_write_in;
  logic              mem_to_reg_in;
  logic              reg_write_in;
  // DM side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] mem_address_out;
  logic [DATA_W-1:0] write_data_out;
  logic [RD_W-1:0]   rd_out;
  logic              mem_read_out;
  logic              mem_write_out;
  logic              mem_to_reg_out;
  logic              reg_write_out;

  modport slave (
    input  flush, in_valid, alu_result_in, write_data_in, rd_in,
           mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, out_ready,
    output in_ready, out_valid, mem_address_out, write_data_out, rd_out,
           mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out
  );

  modport master (
    output flush, in_valid, alu_result_in, write_data_in, rd_in,
           mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, out_ready,
    input  in_ready, out_valid, mem_address_out, write_data_out, rd_out,
           mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out
  );
endinterface

// File: rtl/ex_dm_pipe_stage.sv
// EX->DM pipeline stage: main entry drives DM, skid entry absorbs the beat that
// arrives while DM stalls. in_ready is a flop so it never follows out_ready
// combinationally. Controls are masked on bubbles so a bubble cannot write.
module ex_dm_pipe_stage #(
  parameter int DATA_W    = 32,
  parameter int RD_W      = 5,
  parameter int ZERO_KILL = 1
) (
  input  logic         clk,
  input  logic         reset,
  ex_dm_pipe_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [RD_W-1:0]   rd;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
  } beat_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_q, state_d;
  beat_t  main_q, skid_q, in_beat;
  logic   in_ready_q;
  logic   accept, issue, out_valid;
  logic   load_main_in, load_skid, move_skid;

  assign in_beat = '{addr:       bus.alu_result_in,
                     wdata:      bus.write_data_in,
                     rd:         bus.rd_in,
                     mem_read:   bus.mem_read_in,
                     mem_write:  bus.mem_write_in,
                     mem_to_reg: bus.mem_to_reg_in,
                     reg_write:  bus.reg_write_in};

  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid & in_ready_q;
  assign issue     = out_valid & bus.out_ready;

  // Next occupancy and which entry loads; flush wins over accept and issue
  always_comb begin
    state_d      = state_q;
    load_main_in = 1'b0;
    load_skid    = 1'b0;
    move_skid    = 1'b0;
    unique case (state_q)
      EMPTY: if (accept) begin
        state_d      = ONE;
        load_main_in = 1'b1;
      end
      ONE: begin
        if (accept && issue) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (issue) begin
          state_d = EMPTY;
        end
      end
      TWO: if (issue) begin
        state_d   = ONE;
        move_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (bus.flush) begin
      state_d      = EMPTY;
      load_main_in = 1'b0;
      load_skid    = 1'b0;
      move_skid    = 1'b0;
    end
  end

  // State, registered ready and the two storage entries
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      if (load_main_in)   main_q <= in_beat;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_beat;
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.out_valid       = out_valid;
  assign bus.mem_address_out = main_q.addr;
  assign bus.write_data_out  = main_q.wdata;
  assign bus.rd_out          = main_q.rd;
  assign bus.mem_read_out    = out_valid & main_q.mem_read;
  assign bus.mem_write_out   = out_valid & main_q.mem_write;
  assign bus.mem_to_reg_out  = out_valid & main_q.mem_to_reg;
  // Writes to x0 are dropped here so WB never has to special-case them
  assign bus.reg_write_out   = out_valid & main_q.reg_write &
                               ((ZERO_KILL != 0) ? (main_q.rd != '0) : 1'b1);

endmodule

// File: tb/tb_ex_dm_pipe_stage.sv
// Bench for ex_dm_pipe_stage: a 2-deep FIFO queue model fed by the driver,
// checked by a negedge monitor. A second instance with ZERO_KILL=0 shares the
// same stimulus so both reg_write behaviours are observed on every beat.
module tb_ex_dm_pipe_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic running = 1'b0;
  int   tests = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  ex_dm_pipe_if #(.DATA_W(32), .RD_W(5)) bus ();
  ex_dm_pipe_if #(.DATA_W(32), .RD_W(5)) bus0 ();

  ex_dm_pipe_stage #(.DATA_W(32), .RD_W(5), .ZERO_KILL(1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  ex_dm_pipe_stage #(.DATA_W(32), .RD_W(5), .ZERO_KILL(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  assign bus0.flush         = bus.flush;
  assign bus0.in_valid      = bus.in_valid;
  assign bus0.alu_result_in = bus.alu_result_in;
  assign bus0.write_data_in = bus.write_data_in;
  assign bus0.rd_in         = bus.rd_in;
  assign bus0.mem_read_in   = bus.mem_read_in;
  assign bus0.mem_write_in  = bus.mem_write_in;
  assign bus0.mem_to_reg_in = bus.mem_to_reg_in;
  assign bus0.reg_write_in  = bus.reg_write_in;
  assign bus0.out_ready     = bus.out_ready;

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [3:0]  ctl;   // {mem_read, mem_write, mem_to_reg, reg_write}
  } beat_t;

  beat_t exp_q[$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      if (errs <= 20) $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare the presented beat with the queue head, pop on a DM handshake
  always @(negedge clk) begin
    if (running && !reset) begin
      logic  ev;
      beat_t h;
      ev = (exp_q.size() > 0);
      h  = ev ? exp_q[0] : '{32'd0, 32'd0, 5'd0, 4'd0};
      chk("status",
          {bus.out_valid, bus.in_ready, bus.mem_read_out, bus.mem_write_out,
           bus.mem_to_reg_out, bus.reg_write_out, bus0.out_valid, bus0.reg_write_out},
          {ev, exp_q.size() < 2, h.ctl[3], h.ctl[2], h.ctl[1],
           h.ctl[0] && (h.rd != 5'd0), ev, h.ctl[0]});
      if (ev) begin
        chk("data", {bus.mem_address_out, bus.write_data_out, bus.rd_out},
                    {h.a, h.wd, h.rd});
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; called just after a rising edge, returns just after the next
  task automatic drive_cycle(input logic iv, input logic [31:0] a, input logic [31:0] wd,
                             input logic [4:0] rd, input logic [3:0] ctl,
                             input logic ordy, input logic fl);
    logic acc;
    bus.in_valid      = iv;
    bus.alu_result_in = a;
    bus.write_data_in = wd;
    bus.rd_in         = rd;
    {bus.mem_read_in, bus.mem_write_in, bus.mem_to_reg_in, bus.reg_write_in} = ctl;
    bus.out_ready     = ordy;
    bus.flush         = fl;
    acc = iv && (exp_q.size() < 2);
    @(posedge clk);
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back('{a, wd, rd, ctl});
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive_cycle(1'b0, 32'd0, 32'd0, 5'd0, 4'd0, ordy, 1'b0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.alu_result_in = '0; bus.write_data_in = '0; bus.rd_in = '0;
    bus.mem_read_in = 1'b0; bus.mem_write_in = 1'b0; bus.mem_to_reg_in = 1'b0;
    bus.reg_write_in = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    #12;
    chk("reset_state",
        {bus.out_valid, bus.in_ready, bus.mem_read_out, bus.mem_write_out, bus.mem_to_reg_out,
         bus.reg_write_out, bus.mem_address_out, bus.write_data_out, bus.rd_out},
        {1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0});
    @(posedge clk); #1;
    reset = 1'b0;
    running = 1'b1;

    // Single store beat, then an 8-beat stream at full rate
    drive_cycle(1'b1, 32'h10, 32'hAA, 5'd3, 4'b0100, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      drive_cycle(1'b1, 32'h100 + i, 32'h5000 + i, 5'(i + 1), 4'(i), 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);

    // Stall: A and B fill both entries, C is refused, then all drain in order
    drive_cycle(1'b1, 32'hA, 32'hA0, 5'd1, 4'b1011, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hB, 32'hB0, 5'd2, 4'b0100, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hC, 32'hC0, 5'd3, 4'b1001, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hC, 32'hC0, 5'd3, 4'b1001, 1'b1, 1'b0);
    drive_cycle(1'b1, 32'hC, 32'hC0, 5'd3, 4'b1001, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Flush while full with a beat offered
    drive_cycle(1'b1, 32'hD, 32'hD0, 5'd4, 4'b1111, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hE, 32'hE0, 5'd5, 4'b1111, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hF, 32'hF0, 5'd6, 4'b1111, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1);

    // rd=0 with reg_write: killed only in the ZERO_KILL=1 instance
    drive_cycle(1'b1, 32'h20, 32'h21, 5'd0, 4'b0011, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1); idle(1'b1);

    // Asynchronous reset between edges while holding beats
    drive_cycle(1'b1, 32'h30, 32'h31, 5'd7, 4'b1111, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h40, 32'h41, 5'd8, 4'b1111, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_async",
        {bus.out_valid, bus.in_ready, bus.mem_read_out, bus.mem_write_out, bus.mem_to_reg_out,
         bus.reg_write_out, bus.mem_address_out, bus.write_data_out, bus.rd_out},
        {1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0});
    exp_q.delete();
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1'b1);

    // Random valid/ready/flush traffic
    for (int i = 0; i < 10000; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      drive_cycle($urandom_range(0, 3) != 0, $urandom, $urandom, rd, 4'($urandom),
                  ((i / 64) % 3 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    if (exp_q.size() != 0) chk("drain", 128'(exp_q.size()), 128'd0);

    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
